if_id_fetch_buffer: RTL

- Decoupling queue between the instruction-fetch stage and the decode (ID) stage.
- Tracks in-flight instruction-memory requests and pairs each returned instruction with its PC.
- Buffers fetched instructions so ID stalls (IDWriteEn low) do not lose fetch data.
- On IF/ID flushes (exception, ertn, fetch-again, branch redirect), drops buffered instructions and discards stale in-flight responses.

---
 rtl/if_id_fetch_buffer.sv | 82 ++++++++
 1 files changed

// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer: IF->ID instruction queue that pairs in-order fetch responses with their PCs and discards stale in-flight responses on flush
module if_id_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 3,
  parameter int PC_W = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_req_fire,
  input  logic [PC_W-1:0]            if_req_pc,
  output logic                       if_req_allow,
  input  logic                       inst_rvalid,
  input  logic [INST_W-1:0]          inst_rdata,
  input  logic                       if_flush,
  input  logic                       id_flush,
  input  logic                       id_write_en,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       proto_err
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PIW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
  logic [PC_W-1:0]   q_pc [DEPTH];
  logic [INST_W-1:0] q_inst [DEPTH];
  logic [PC_W-1:0]   p_pc [MAX_OUTSTANDING];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [PIW-1:0]    p_head, p_tail;
  logic [PCW-1:0]    pending_cnt, discard_cnt, live_pending;
  logic              flush, resp_ok, p_push, keep, full, pop, push;
  function automatic logic [PIW-1:0] p_next(input logic [PIW-1:0] p);
    return p == PIW'(MAX_OUTSTANDING - 1) ? '0 : p + PIW'(1);
  endfunction
  always_comb begin
    flush        = if_flush | id_flush;
    resp_ok      = inst_rvalid && pending_cnt != '0;
    p_push       = if_req_fire && (pending_cnt != PCW'(MAX_OUTSTANDING) || resp_ok);
    keep         = resp_ok && discard_cnt == '0 && !flush;
    full         = count == CW'(DEPTH);
    pop          = id_valid && id_write_en && !flush;
    push         = keep && (!full || pop);
    live_pending = pending_cnt - discard_cnt;
  end
  assign if_req_allow = pending_cnt < PCW'(MAX_OUTSTANDING) && 32'(count) + 32'(live_pending) < 32'(DEPTH);
  assign id_valid     = count != '0;
  assign id_pc        = id_valid ? q_pc[head] : '0;
  assign id_inst      = id_valid ? q_inst[head] : '0;
  assign occupancy    = count;
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= p_pc[p_head];
      q_inst[tail] <= inst_rdata;
    end
    if (p_push) p_pc[p_tail] <= if_req_pc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      p_head      <= '0;
      p_tail      <= '0;
      pending_cnt <= '0;
      discard_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (p_push) p_tail <= p_next(p_tail);
      if (resp_ok) p_head <= p_next(p_head);
      pending_cnt <= pending_cnt + PCW'(p_push) - PCW'(resp_ok);
      discard_cnt <= flush ? pending_cnt - PCW'(resp_ok) : discard_cnt - PCW'(resp_ok && discard_cnt != '0);
      head        <= flush ? '0 : head + AW'(pop);
      tail        <= flush ? '0 : tail + AW'(push);
      count       <= flush ? '0 : count + CW'(push) - CW'(pop);
      if ((inst_rvalid && pending_cnt == '0) || (keep && full && !pop)) proto_err <= 1'b1;
    end
  end
endmodule
